// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over req/ack, hands them
// to decode over valid/ready and computes the next PC on retirement.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  pcn_control,
    input  logic [31:0] imm32,
    input  logic [31:0] rs1_val,
    input  logic        branch_taken,
    input  logic        finish,
    output logic        halted,
    output logic        misaligned
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] NPC_4      = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JAL    = 2'd2;
    localparam logic [1:0] NPC_JALR   = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc_n, instr_n, npc;
    logic [XLEN-1:0]   pc_plus4, pc_target, jalr_target;
    logic              halted_n, misaligned_n;

    assign imem_addr = pc;

    // Next-PC candidates, all modulo 2^32
    always_comb begin
        pc_plus4    = pc + XLEN'(4);
        pc_target   = pc + imm32;
        jalr_target = (rs1_val + imm32) & ~XLEN'(1);
        npc         = pc_plus4;
        case (pcn_control)
            NPC_4:      npc = pc_plus4;
            NPC_BRANCH: npc = branch_taken ? pc_target : pc_plus4;
            NPC_JAL:    npc = pc_target;
            NPC_JALR:   npc = jalr_target;
            default:    npc = pc_plus4;
        endcase
    end

    // Next-state and next-register values
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        instr_n      = instr;
        halted_n     = halted;
        misaligned_n = misaligned;
        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_n = imem_rdata;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (instr_valid && instr_ready) begin
                    instr_n = NOP_INSTR;
                    if (finish) begin
                        state_n  = HALT;
                        halted_n = 1'b1;
                    end else if (npc[1:0] != 2'b00) begin
                        state_n      = HALT;
                        halted_n     = 1'b1;
                        misaligned_n = 1'b1;
                    end else begin
                        pc_n    = npc;
                        state_n = REQ;
                    end
                end
            end
            HALT:    state_n = HALT;
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            imem_req    <= (state_n == REQ);
            instr_valid <= (state_n == HOLD);
            halted      <= halted_n;
            misaligned  <= misaligned_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, ack latency, stalls,
// next-PC selection, halting and reset during an outstanding request.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  pcn_control;
    logic [31:0] imm32;
    logic [31:0] rs1_val;
    logic        branch_taken;
    logic        finish;
    logic        halted;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .pc(pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pcn_control(pcn_control), .imm32(imm32), .rs1_val(rs1_val),
        .branch_taken(branch_taken), .finish(finish),
        .halted(halted), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle same-cycle ack of the given word
    task automatic give_word(input logic [31:0] w);
        imem_ack   = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack   = 1'b0;
    endtask

    // Retire the held instruction with the given next-PC controls
    task automatic retire(input logic [1:0] code, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic bt, input logic fin);
        pcn_control  = code;
        imm32        = imm;
        rs1_val      = rs1;
        branch_taken = bt;
        finish       = fin;
        instr_ready  = 1'b1;
        tick();
        instr_ready  = 1'b0;
        finish       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({imem_req, imem_addr, instr_valid, pc, instr, halted, misaligned} !==
            {1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state req=%b addr=%h v=%b pc=%h instr=%h h=%b m=%b",
                     imem_req, imem_addr, instr_valid, pc, instr, halted, misaligned);
        end
    endtask

    task automatic test_zero_latency();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL first_req req=%b addr=%h v=%b (want 1 00000000 0)", imem_req, imem_addr, instr_valid);
        end
        give_word(32'h00A0_0093);
        checks++;
        if ({instr_valid, instr, pc, imem_req} !== {1'b1, 32'h00A0_0093, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL first_deliver v=%b instr=%h pc=%h req=%b", instr_valid, instr, pc, imem_req);
        end
        retire(2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr} !== {1'b1, 32'h4, 1'b0, NOP}) begin
            failures++;
            $display("FAIL seq_npc req=%b addr=%h v=%b instr=%h (want 1 00000004 0 %h)",
                     imem_req, imem_addr, instr_valid, instr, NOP);
        end
    endtask

    task automatic test_ack_latency();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h4, 1'b0}) begin
                failures++;
                $display("FAIL wait_ack[%0d] req=%b addr=%h v=%b (want 1 00000004 0)",
                         i, imem_req, imem_addr, instr_valid);
            end
        end
        give_word(32'h0011_0113);
        checks++;
        if ({instr_valid, instr, pc} !== {1'b1, 32'h0011_0113, 32'h4}) begin
            failures++;
            $display("FAIL late_deliver v=%b instr=%h pc=%h", instr_valid, instr, pc);
        end
    endtask

    task automatic test_stall_branch();
        retire(2'd2, 32'h1C, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h20}) begin
            failures++;
            $display("FAIL jal_npc req=%b addr=%h (want 1 00000020)", imem_req, imem_addr);
        end
        give_word(32'h0000_0063);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({instr_valid, instr, pc, imem_req} !== {1'b1, 32'h0000_0063, 32'h20, 1'b0}) begin
                failures++;
                $display("FAIL stall[%0d] v=%b instr=%h pc=%h req=%b", i, instr_valid, instr, pc, imem_req);
            end
        end
        retire(2'd1, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h18}) begin
            failures++;
            $display("FAIL branch_taken addr=%h req=%b (want 00000018 1)", imem_addr, imem_req);
        end
        give_word(32'h0000_006F);
        retire(2'd2, 32'h8, 32'h0, 1'b0, 1'b0);
        give_word(32'h0000_0063);
        retire(2'd1, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h24}) begin
            failures++;
            $display("FAIL branch_not_taken addr=%h req=%b (want 00000024 1)", imem_addr, imem_req);
        end
    endtask

    task automatic test_jalr();
        give_word(32'h0000_0067);
        retire(2'd3, 32'h3, 32'h101, 1'b0, 1'b0);
        checks++;
        if ({imem_req, imem_addr, halted} !== {1'b1, 32'h104, 1'b0}) begin
            failures++;
            $display("FAIL jalr_ok req=%b addr=%h h=%b (want 1 00000104 0)", imem_req, imem_addr, halted);
        end
        give_word(32'h0000_0067);
        retire(2'd3, 32'h2, 32'h101, 1'b0, 1'b0);
        checks++;
        if ({halted, misaligned, imem_req, instr_valid, pc} !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h104}) begin
            failures++;
            $display("FAIL jalr_misaligned h=%b m=%b req=%b v=%b pc=%h (want 1 1 0 0 00000104)",
                     halted, misaligned, imem_req, instr_valid, pc);
        end
        tick();
        tick();
        checks++;
        if ({halted, misaligned, imem_req, pc} !== {1'b1, 1'b1, 1'b0, 32'h104}) begin
            failures++;
            $display("FAIL halt_sticky h=%b m=%b req=%b pc=%h", halted, misaligned, imem_req, pc);
        end
    endtask

    task automatic test_finish();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        give_word(32'h0000_0073);
        retire(2'd3, 32'h2, 32'h101, 1'b0, 1'b1);
        checks++;
        if ({halted, misaligned, imem_req, instr_valid, pc} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL finish_halt h=%b m=%b req=%b v=%b pc=%h (want 1 0 0 0 00000000)",
                     halted, misaligned, imem_req, instr_valid, pc);
        end
        imem_ack    = 1'b1;
        imem_rdata  = 32'h1234_5678;
        instr_ready = 1'b1;
        tick();
        tick();
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        checks++;
        if ({halted, misaligned, imem_req, instr_valid, pc, instr} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, NOP}) begin
            failures++;
            $display("FAIL halt_ignores h=%b m=%b req=%b v=%b pc=%h instr=%h",
                     halted, misaligned, imem_req, instr_valid, pc, instr);
        end
    endtask

    task automatic test_reset_in_req();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        give_word(32'h0000_0013);
        retire(2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin
            failures++;
            $display("FAIL pre_reset_req req=%b addr=%h (want 1 00000004)", imem_req, imem_addr);
        end
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({instr, instr_valid, imem_req, pc} !== {NOP, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_over_ack instr=%h v=%b req=%b pc=%h", instr, instr_valid, imem_req, pc);
        end
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++;
        if ({instr, instr_valid, imem_req, imem_addr} !== {NOP, 1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL stale_ack instr=%h v=%b req=%b addr=%h", instr, instr_valid, imem_req, imem_addr);
        end
        give_word(32'hCAFE_0013);
        checks++;
        if ({instr_valid, instr, pc} !== {1'b1, 32'hCAFE_0013, 32'h0}) begin
            failures++;
            $display("FAIL restart_fetch v=%b instr=%h pc=%h", instr_valid, instr, pc);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        instr_ready  = 1'b0;
        pcn_control  = 2'd0;
        imm32        = 32'h0;
        rs1_val      = 32'h0;
        branch_taken = 1'b0;
        finish       = 1'b0;
        test_reset();
        test_zero_latency();
        test_ack_latency();
        test_stall_branch();
        test_jalr();
        test_finish();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decode controller in the 1-cycle core. It owns the PC register and issues word reads to instruction memory over a req/ack handshake. It presents the fetched instruction and its PC to decode/execute with a valid/ready handshake. On retirement it computes the next PC from the controller's pcnControl code, imm32, rs1 value and branch result, and halts on ECALL finish or on a misaligned target.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
NOP_INSTR, 32'h0000_0013, instruction register value while no valid instruction is held (addi x0,x0,0).

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
imem_req  out  1  instruction memory read request.
imem_addr  out  32  byte address of the requested word.
imem_ack  in  1  memory returns imem_rdata this cycle; variable latency, including same-cycle.
imem_rdata  in  32  fetched instruction word.
instr  out  32  instruction to the controller.
pc  out  32  PC of instr.
instr_valid  out  1  instr and pc are valid.
instr_ready  in  1  downstream retires the current instruction this cycle.
pcn_control  in  2  next-PC select: 0 = ALU_NPC_4, 1 = ALU_NPC_BRANCH, 2 = ALU_NPC_JAL, 3 = ALU_NPC_JALR.
imm32  in  32  immediate from the controller.
rs1_val  in  32  register-file read of rs1 (JALR base).
branch_taken  in  1  ALU compare result for the branch.
finish  in  1  ECALL retiring.
halted  out  1  core stopped.
misaligned  out  1  halt cause: next PC not word-aligned.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0, halted=0, misaligned=0. Reset takes priority over every other event, including an in-flight request or a pending retire.
- FSM states: IDLE, REQ, HOLD, HALT.
  - IDLE: one cycle after reset deassertion, then REQ.
  - REQ: imem_req=1 and imem_addr=pc, both held stable until imem_ack. Sampling imem_ack=1 at an edge latches instr<=imem_rdata and moves to HOLD; the ack may arrive in the first REQ cycle.
  - HOLD: instr_valid=1; instr and pc are stable until retire. Retire means instr_valid and instr_ready both high at an edge. On retire: instr_valid<=0 and the next PC (npc) is computed. If finish=1, go to HALT with pc unchanged. Else if npc[1:0]!=0, go to HALT with misaligned<=1 and pc unchanged. Else pc<=npc and go to REQ.
  - HALT: terminal until reset. halted=1, imem_req=0, instr_valid=0; all inputs are ignored.
- imem_ack is ignored outside REQ. A stale ack arriving after reset has no effect.
- Throughput: minimum 2 cycles per instruction (REQ with same-cycle ack, then HOLD with ready=1).
- Next-PC rules (32-bit modular arithmetic; wrap-around is allowed, e.g. 32'hFFFF_FFFC+4 = 0):
  - code 0: pc+4.
  - code 1: pc+imm32 if branch_taken, else pc+4.
  - code 2: pc+imm32.
  - code 3: (rs1_val+imm32) & ~32'h1; bit 1 is then checked for misalignment.
- finish takes precedence over the misalignment check when both apply.
- halted and misaligned are registered outputs; they change only on the retire edge or on reset.

Test Plan:
- Reset release with RESET_PC=0, memory ack latency 0 -> imem_req rises 1 cycle after release, addr=0. instr_valid=1 the next cycle with the memory word. With instr_ready=1 and code 0, the next request is at addr 4.
- Ack latency 3 -> imem_req and imem_addr are held stable for 3 cycles, instr_valid stays 0 throughout, and the instruction is delivered on the cycle after the ack.
- HOLD with instr_ready=0 for 4 cycles -> instr and pc are unchanged and instr_valid stays 1. Then ready=1, code 1, branch_taken=1, imm32=-8 at pc=0x20 -> next addr 0x18. The same case with branch_taken=0 -> next addr 0x24.
- JALR with rs1_val=0x101, imm32=2 -> npc=0x102 -> halted=1, misaligned=1, imem_req stays 0 and pc stays put. JALR with rs1_val=0x101, imm32=3 -> next addr 0x104.
- Retire with finish=1 and code 3 producing a misaligned target -> halted=1, misaligned=0. Later acks and ready pulses cause no change.
- rst_n=0 while in REQ, then 0xDEAD_BEEF acked during reset -> next state is IDLE with instr=NOP_INSTR, and the fetch restarts at RESET_PC.
